sys_ctrl: RTL and testbench

- Command sequencer between the UART receiver and the system datapath (register file, ALU, UART transmitter).
- Consumes validated bytes from the RX frame FSM/deserializer (`RX_P_DATA` qualified by `RX_D_VLD`) and decodes multi-byte commands.
- Issues register-file write/read strobes and ALU operations, then schedules the response bytes to the TX path under a busy handshake.

---
 rtl/sys_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sys_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl
// Purpose  : UART command sequencer. Decodes register write/read and ALU
//            commands and schedules response bytes to TX. Optional feature:
//            SYS_CTRL_NACK_EN (unknown command answered with a 0xEE byte).
// Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int OPA_ADDR   = 0,
    parameter int OPB_ADDR   = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    TX_BUSY,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] c_CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_CMD_ALU    = DATA_WIDTH'(8'hDD);
    localparam logic [ADDR_WIDTH-1:0] c_OPA_ADDR   = ADDR_WIDTH'(OPA_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_OPB_ADDR   = ADDR_WIDTH'(OPB_ADDR);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_ALU_OPA  = 4'd5,
        S_ALU_OPB  = 4'd6,
        S_ALU_FUN  = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX_RD    = 4'd9,
        S_TX_LO    = 4'd10,
        S_TX_HI    = 4'd11
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2*DATA_WIDTH-1:0] r_result;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            c_CMD_WR:     r_state <= S_WR_ADDR;
                            c_CMD_RD:     r_state <= S_RD_ADDR;
                            c_CMD_ALU_OP: r_state <= S_ALU_OPA;
                            c_CMD_ALU:    r_state <= S_ALU_FUN;
                            default: begin
`ifdef SYS_CTRL_NACK_EN
                                r_result <= (2*DATA_WIDTH)'(8'hEE);
                                r_state  <= S_TX_RD;
`else
                                r_state  <= S_IDLE;
`endif
                            end
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state <= S_WR_DATA;
                    end
                end
                S_WR_DATA:  if (RX_D_VLD) r_state <= S_IDLE;
                S_RD_ADDR:  if (RX_D_VLD) r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (RdData_Valid) begin
                        r_result <= {{DATA_WIDTH{1'b0}}, RdData};
                        r_state  <= S_TX_RD;
                    end
                end
                S_ALU_OPA:  if (RX_D_VLD) r_state <= S_ALU_OPB;
                S_ALU_OPB:  if (RX_D_VLD) r_state <= S_ALU_FUN;
                S_ALU_FUN:  if (RX_D_VLD) r_state <= S_ALU_WAIT;
                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        r_result <= ALU_OUT;
                        r_state  <= S_TX_LO;
                    end
                end
                // Response states advance only on the cycle the byte is accepted.
                S_TX_RD:    if (!TX_BUSY) r_state <= S_IDLE;
                S_TX_LO:    if (!TX_BUSY) r_state <= S_TX_HI;
                S_TX_HI:    if (!TX_BUSY) r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes coincide with the qualifying input, so outputs decode state and inputs.
    always_comb begin
        WrEn      = 1'b0;
        RdEn      = 1'b0;
        Address   = '0;
        WrData    = '0;
        ALU_EN    = 1'b0;
        ALU_FUN   = '0;
        CLK_EN    = 1'b0;
        TX_P_DATA = '0;
        TX_D_VLD  = 1'b0;
        case (r_state)
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    WrEn    = 1'b1;
                    Address = r_addr;
                    WrData  = RX_P_DATA;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    RdEn    = 1'b1;
                    Address = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            S_ALU_OPA: begin
                if (RX_D_VLD) begin
                    WrEn    = 1'b1;
                    Address = c_OPA_ADDR;
                    WrData  = RX_P_DATA;
                end
            end
            S_ALU_OPB: begin
                if (RX_D_VLD) begin
                    WrEn    = 1'b1;
                    Address = c_OPB_ADDR;
                    WrData  = RX_P_DATA;
                end
            end
            S_ALU_FUN: begin
                CLK_EN = 1'b1;
                if (RX_D_VLD) begin
                    ALU_EN  = 1'b1;
                    ALU_FUN = RX_P_DATA[FUN_WIDTH-1:0];
                end
            end
            S_ALU_WAIT: CLK_EN = 1'b1;
            S_TX_RD, S_TX_LO: begin
                if (!TX_BUSY) begin
                    TX_D_VLD  = 1'b1;
                    TX_P_DATA = r_result[DATA_WIDTH-1:0];
                end
            end
            S_TX_HI: begin
                if (!TX_BUSY) begin
                    TX_D_VLD  = 1'b1;
                    TX_P_DATA = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_ctrl
// Purpose  : Scoreboard bench for sys_ctrl command decoding and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_BUSY = 1'b0;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
    logic [3:0]  Address, ALU_FUN;
    logic [7:0]  WrData, TX_P_DATA;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_fun[$];
    logic [7:0]  exp_tx[$];

    sys_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_BUSY(TX_BUSY),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every strobe observed must match the head of its queue.
    always @(negedge CLK) begin
        if (mon_en) begin
            n_checks++;
            if (TX_D_VLD && TX_BUSY) begin
                n_fail++;
                $display("FAIL tx_while_busy: TX_D_VLD=1 with TX_BUSY=1, required no strobe");
            end
            if (WrEn) begin
                n_checks++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: got WrEn addr=%0h data=%0h, required none", Address, WrData);
                end else begin
                    logic [11:0] e;
                    e = exp_wr.pop_front();
                    if ({Address, WrData} !== e) begin
                        n_fail++;
                        $display("FAIL wr_value: got addr=%0h data=%0h, required addr=%0h data=%0h",
                                 Address, WrData, e[11:8], e[7:0]);
                    end
                end
            end
            if (RdEn) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected: got RdEn addr=%0h, required none", Address);
                end else begin
                    logic [3:0] e;
                    e = exp_rd.pop_front();
                    if (Address !== e || WrData !== 8'h00) begin
                        n_fail++;
                        $display("FAIL rd_value: got addr=%0h wrdata=%0h, required addr=%0h wrdata=0", Address, WrData, e);
                    end
                end
            end
            if (ALU_EN) begin
                n_checks++;
                if (exp_fun.size() == 0) begin
                    n_fail++;
                    $display("FAIL alu_unexpected: got ALU_EN fun=%0h, required none", ALU_FUN);
                end else begin
                    logic [3:0] e;
                    e = exp_fun.pop_front();
                    if (ALU_FUN !== e || CLK_EN !== 1'b1) begin
                        n_fail++;
                        $display("FAIL alu_value: got fun=%0h clk_en=%b, required fun=%0h clk_en=1", ALU_FUN, CLK_EN, e);
                    end
                end
            end
            if (TX_D_VLD) begin
                n_checks++;
                if (exp_tx.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %0h, required none", TX_P_DATA);
                end else begin
                    logic [7:0] e;
                    e = exp_tx.pop_front();
                    if (TX_P_DATA !== e) begin
                        n_fail++;
                        $display("FAIL tx_value: got %0h, required %0h", TX_P_DATA, e);
                    end
                end
            end
            n_checks++;
            if ((!WrEn && !RdEn && (Address !== 4'h0 || WrData !== 8'h00)) ||
                (!TX_D_VLD && TX_P_DATA !== 8'h00)) begin
                n_fail++;
                $display("FAIL idle_zero: got addr=%0h wrdata=%0h txdata=%0h, required all 0",
                         Address, WrData, TX_P_DATA);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick(1);
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
    endtask

    task automatic pulse_rd(input logic [7:0] d);
        RdData = d; RdData_Valid = 1'b1;
        tick(1);
        RdData_Valid = 1'b0; RdData = '0;
    endtask

    task automatic pulse_alu(input logic [15:0] r);
        ALU_OUT = r; ALU_OUT_VLD = 1'b1;
        tick(1);
        ALU_OUT_VLD = 1'b0; ALU_OUT = '0;
    endtask

    task automatic wait_tx(input string name, input int budget);
        int k;
        k = 0;
        while (exp_tx.size() != 0 && k < budget) begin tick(1); k++; end
        n_checks++;
        if (exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL %s_tx_timeout: %0d bytes outstanding, required 0", name, exp_tx.size());
            exp_tx.delete();
        end
    endtask

    task automatic check_drained(input string name);
        tick(2);
        n_checks++;
        if (exp_wr.size() + exp_rd.size() + exp_fun.size() + exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: wr=%0d rd=%0d fun=%0d tx=%0d pending, required 0",
                     name, exp_wr.size(), exp_rd.size(), exp_fun.size(), exp_tx.size());
        end
        exp_wr.delete(); exp_rd.delete(); exp_fun.delete(); exp_tx.delete();
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge CLK);
        n_checks++;
        if ({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs during reset, required all 0");
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        tick(1);
        @(negedge CLK);
        n_checks++;
        if ({WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got strobes=%b, required 00000", {WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD});
        end
        @(posedge CLK); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_write();
        exp_wr.push_back({4'h5, 8'h3C});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        check_drained("write");
    endtask

    task automatic test_read();
        exp_rd.push_back(4'h5);
        send_byte(8'hBB); send_byte(8'h05);
        tick(1);
        exp_tx.push_back(8'h3C);
        pulse_rd(8'h3C);
        wait_tx("read", 10);
        check_drained("read");
    endtask

    task automatic test_alu_ops();
        exp_wr.push_back({4'h0, 8'h12});
        exp_wr.push_back({4'h1, 8'h34});
        exp_fun.push_back(4'h0);
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34);
        @(negedge CLK);
        n_checks++;
        if (CLK_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_clk_en_fun: got %b, required 1", CLK_EN);
        end
        @(posedge CLK); #1;
        send_byte(8'h00);
        @(negedge CLK);
        n_checks++;
        if (CLK_EN !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_clk_en_wait: got %b, required 1", CLK_EN);
        end
        @(posedge CLK); #1;
        exp_tx.push_back(8'h46);
        exp_tx.push_back(8'h00);
        pulse_alu(16'h0046);
        wait_tx("alu_ops", 10);
        @(negedge CLK);
        n_checks++;
        if (CLK_EN !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_clk_en_idle: got %b, required 0", CLK_EN);
        end
        @(posedge CLK); #1;
        check_drained("alu_ops");
    endtask

    task automatic test_busy();
        exp_fun.push_back(4'h2);
        send_byte(8'hDD); send_byte(8'h02);
        TX_BUSY = 1'b1;
        pulse_alu(16'hABCD);
        tick(10);
        n_checks++;
        if (exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL busy_premature: %0d tx queued, required 0", exp_tx.size());
        end
        exp_tx.push_back(8'hCD);
        exp_tx.push_back(8'hAB);
        TX_BUSY = 1'b0;
        wait_tx("busy", 10);
        check_drained("busy");
    endtask

    task automatic test_unknown_drop();
        pulse_rd(8'h77);
        pulse_alu(16'h5555);
`ifdef SYS_CTRL_NACK_EN
        exp_tx.push_back(8'hEE);
`endif
        send_byte(8'h55);
        wait_tx("nack", 10);
        tick(2);
        exp_fun.push_back(4'h3);
        send_byte(8'hDD); send_byte(8'h03);
        send_byte(8'hBB);
        TX_BUSY = 1'b1;
        pulse_alu(16'h1234);
        send_byte(8'hAA);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h12);
        TX_BUSY = 1'b0;
        wait_tx("drop", 10);
        check_drained("drop");
    endtask

    task automatic test_back_to_back();
        exp_wr.push_back({4'h1, 8'h11});
        exp_wr.push_back({4'h2, 8'h22});
        exp_rd.push_back(4'h2);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h22);
        send_byte(8'hBB); send_byte(8'h02);
        exp_tx.push_back(8'h22);
        pulse_rd(8'h22);
        wait_tx("b2b", 10);
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hAA); send_byte(8'h05);
        RX_P_DATA = 8'h3C; RX_D_VLD = 1'b1;
        RST = 1'b0;
        #1;
        n_checks++;
        if ({WrEn, RdEn, Address, WrData, ALU_EN, CLK_EN, TX_D_VLD} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got WrEn=%b addr=%0h data=%0h, required all 0", WrEn, Address, WrData);
        end
        tick(1);
        RX_D_VLD = 1'b0; RX_P_DATA = '0;
        tick(1);
        RST = 1'b1;
        tick(1);
        exp_rd.push_back(4'h5);
        send_byte(8'hBB); send_byte(8'h05);
        tick(1);
        exp_tx.push_back(8'h99);
        pulse_rd(8'h99);
        wait_tx("reset_mid", 10);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_ops();
        test_busy();
        test_unknown_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
